vga_timing_gen: RTL

Parametrised VGA raster timing generator. It replaces the fixed pixel counter and sync generator pair that currently drive the colour pipeline. Horizontal and vertical timings, sync polarities, pixel-clock division and output pipeline delay are all set by parameters. The block adds frame/line strobes and a run enable, so one RTL block serves the 640x480 (25 MHz) and 800x600 (40 MHz) modes and aligns its syncs with a multi-stage colour path.

---
 rtl/vga_timing_gen.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised VGA raster timing generator with pixel-clock divider,
//            line/frame strobes, run enable and matched output pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int PIX_DIV  = 1,
  parameter int PIPE     = 0,
  parameter int CNT_W    = 11
) (
  input  logic             clk40m,
  input  logic             rst,
  input  logic             run,
  output logic [CNT_W-1:0] hcntout,
  output logic [CNT_W-1:0] vcntout,
  output logic             hsync,
  output logic             vsync,
  output logic             henable,
  output logic             venable,
  output logic             pix_en,
  output logic             line_start,
  output logic             frame_start
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (c_H_TOTAL > (1 << CNT_W) || c_V_TOTAL > (1 << CNT_W)) begin : g_err_total
      $error("vga_timing_gen: raster totals exceed counter range");
    end
    if (PIX_DIV < 1 || PIX_DIV > 8) begin : g_err_div
      $error("vga_timing_gen: PIX_DIV out of range 1..8");
    end
    if (PIPE < 0 || PIPE > 4) begin : g_err_pipe
      $error("vga_timing_gen: PIPE out of range 0..4");
    end
  endgenerate

  // One extra bit so the comparisons stay exact even when a total is 2^CNT_W
  typedef logic [CNT_W:0] cmp_t;

  localparam logic [2:0] c_DIV_LAST = 3'(PIX_DIV - 1);
  localparam cmp_t c_H_LAST   = cmp_t'(c_H_TOTAL - 1);
  localparam cmp_t c_V_LAST   = cmp_t'(c_V_TOTAL - 1);
  localparam cmp_t c_H_ACT    = cmp_t'(H_ACTIVE);
  localparam cmp_t c_V_ACT    = cmp_t'(V_ACTIVE);
  localparam cmp_t c_HS_START = cmp_t'(H_ACTIVE + H_FP);
  localparam cmp_t c_HS_END   = cmp_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cmp_t c_VS_START = cmp_t'(V_ACTIVE + V_FP);
  localparam cmp_t c_VS_END   = cmp_t'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic             hs;
    logic             vs;
    logic             he;
    logic             ve;
    logic             pe;
    logic             ls;
    logic             fs;
  } out_t;

  localparam out_t c_IDLE = '{h: '0, v: '0, hs: ~HS_POL, vs: ~VS_POL,
                              he: 1'b0, ve: 1'b0, pe: 1'b0, ls: 1'b0, fs: 1'b0};

  logic [2:0]       r_dcnt;
  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;
  logic             w_pe;
  cmp_t             w_h_ext;
  cmp_t             w_v_ext;
  out_t             w_dec;
  out_t             r_pipe [PIPE+1];

  assign w_pe    = (r_dcnt == c_DIV_LAST);
  assign w_h_ext = {1'b0, r_h};
  assign w_v_ext = {1'b0, r_v};

  always_ff @(posedge clk40m or posedge rst) begin
    if (rst) begin
      r_dcnt <= 3'd0;
      r_h    <= '0;
      r_v    <= '0;
    end else if (!run) begin
      r_dcnt <= 3'd0;
      r_h    <= '0;
      r_v    <= '0;
    end else begin
      r_dcnt <= w_pe ? 3'd0 : r_dcnt + 3'd1;
      if (w_pe) begin
        if (w_h_ext == c_H_LAST) begin
          r_h <= '0;
          r_v <= (w_v_ext == c_V_LAST) ? '0 : r_v + 1'b1;
        end else begin
          r_h <= r_h + 1'b1;
        end
      end
    end
  end

  // Stopped generator presents the idle raster, independent of stale state
  always_comb begin
    w_dec = c_IDLE;
    if (run) begin
      w_dec.h  = r_h;
      w_dec.v  = r_v;
      w_dec.hs = ((w_h_ext >= c_HS_START) && (w_h_ext < c_HS_END)) ? HS_POL : ~HS_POL;
      w_dec.vs = ((w_v_ext >= c_VS_START) && (w_v_ext < c_VS_END)) ? VS_POL : ~VS_POL;
      w_dec.he = (w_h_ext < c_H_ACT);
      w_dec.ve = (w_v_ext < c_V_ACT);
      w_dec.pe = w_pe;
      w_dec.ls = w_pe && (r_h == '0);
      w_dec.fs = w_pe && (r_h == '0) && (r_v == '0);
    end
  end

  always_ff @(posedge clk40m or posedge rst) begin
    if (rst) r_pipe[0] <= c_IDLE;
    else     r_pipe[0] <= w_dec;
  end

  generate
    for (genvar i = 1; i <= PIPE; i++) begin : g_pipe
      always_ff @(posedge clk40m or posedge rst) begin
        if (rst) r_pipe[i] <= c_IDLE;
        else     r_pipe[i] <= r_pipe[i-1];
      end
    end
  endgenerate

  assign hcntout     = r_pipe[PIPE].h;
  assign vcntout     = r_pipe[PIPE].v;
  assign hsync       = r_pipe[PIPE].hs;
  assign vsync       = r_pipe[PIPE].vs;
  assign henable     = r_pipe[PIPE].he;
  assign venable     = r_pipe[PIPE].ve;
  assign pix_en      = r_pipe[PIPE].pe;
  assign line_start  = r_pipe[PIPE].ls;
  assign frame_start = r_pipe[PIPE].fs;

endmodule
`default_nettype wire
